// File: rtl/gold_seq_gen.sv
// Streaming Gold sequence generator: x1/x2 LFSR pair with an NC warm-up phase,
// then length-bounded N_GEN_BIT-wide words under valid/ready flow control.
module gold_seq_gen #(
    parameter int N_GEN_BIT = 8,
    parameter int NC        = 1600,
    parameter int LEN_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [30:0]          i_c_init,
    input  logic [LEN_W-1:0]     i_len,
    input  logic                 i_abort,
    input  logic                 i_ready,
    output logic [N_GEN_BIT-1:0] o_seq,
    output logic                 o_valid,
    output logic                 o_last,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int             WARM_STEPS = NC / N_GEN_BIT;
    localparam int             CNT_W      = (WARM_STEPS > 1) ? $clog2(WARM_STEPS) : 1;
    localparam logic [LEN_W:0] WORD_LEN   = (LEN_W + 1)'(N_GEN_BIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [30:0]      x1, x2;
    logic [30:0]      x1_step, x2_step;
    logic [LEN_W-1:0] rem;
    logic [CNT_W-1:0] warm_cnt;
    logic             done, done_next;
    logic             start_ok, accept, final_word;

    assign start_ok   = (state == IDLE) && i_start && (i_len != '0);
    assign final_word = ({1'b0, rem} <= WORD_LEN);
    assign accept     = (state == RUN) && i_ready && !i_abort;

    // Both registers hold a 31-element window with bit 0 the oldest element;
    // one step slides the window forward by N_GEN_BIT positions.
    always_comb begin
        x1_step = x1;
        x2_step = x2;
        // NOTE: blocking assignments here build an unrolled chain of single-bit
        // shifts inside one combinational block; each iteration sees the last.
        for (int i = 0; i < N_GEN_BIT; i++) begin
            x1_step = {x1_step[3] ^ x1_step[0], x1_step[30:1]};
            x2_step = {x2_step[3] ^ x2_step[2] ^ x2_step[1] ^ x2_step[0], x2_step[30:1]};
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_next = WARM;
            end
            WARM: begin
                if (i_abort)              state_next = IDLE;
                else if (warm_cnt == '0)  state_next = RUN;
            end
            RUN: begin
                if (i_abort) begin
                    state_next = IDLE;
                end else if (i_ready && final_word) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: the LFSR and length registers are reset as well, so a request cut
    // short by reset can never leave a stale window that later leaks to o_seq.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1       <= '0;
            x2       <= '0;
            rem      <= '0;
            warm_cnt <= '0;
            done     <= 1'b0;
        end else begin
            done <= done_next;
            if (start_ok) begin
                x1       <= 31'd1;
                x2       <= i_c_init;
                rem      <= i_len;
                warm_cnt <= CNT_W'(WARM_STEPS - 1);
            end else if (state == WARM && !i_abort) begin
                x1       <= x1_step;
                x2       <= x2_step;
                warm_cnt <= warm_cnt - CNT_W'(1);
            end else if (accept) begin
                x1  <= x1_step;
                x2  <= x2_step;
                rem <= final_word ? '0 : rem - WORD_LEN[LEN_W-1:0];
            end
        end
    end

    // Bits past the requested length are zeroed so the tail word is clean.
    always_comb begin
        o_seq = '0;
        if (state == RUN) begin
            for (int k = 0; k < N_GEN_BIT; k++) begin
                if ((LEN_W + 1)'(k) < {1'b0, rem}) o_seq[k] = x1[k] ^ x2[k];
            end
        end
    end

    assign o_valid = (state == RUN);
    assign o_last  = (state == RUN) && final_word;
    assign o_busy  = (state != IDLE);
    assign o_done  = done;

endmodule

// File: tb/tb_gold_seq_gen.sv
// Self-checking bench for gold_seq_gen: a bit-serial Gold sequence model drives a
// per-cycle expectation for the 8-bit build, plus 25-bit and 1-bit builds.
module tb_gold_seq_gen;

    localparam int NG   = 8;
    localparam int NC   = 1600;
    localparam int LW   = 16;
    localparam int MAXL = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort, ready;
    logic [30:0]   c_init;
    logic [LW-1:0] len;
    logic [NG-1:0] seq;
    logic          valid, last, busy, done;

    logic          start25, start1;
    logic [30:0]   ci25, ci1;
    logic [LW-1:0] len25, len1;
    logic [24:0]   seq25;
    logic [0:0]    seq1;
    logic          valid25, last25, busy25, done25;
    logic          valid1, last1, busy1, done1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gold_seq_gen #(.N_GEN_BIT(NG), .NC(NC), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_c_init(c_init), .i_len(len),
        .i_abort(abort), .i_ready(ready), .o_seq(seq), .o_valid(valid), .o_last(last),
        .o_busy(busy), .o_done(done)
    );

    gold_seq_gen #(.N_GEN_BIT(25), .NC(NC), .LEN_W(LW)) dut25 (
        .clk(clk), .rst_n(rst_n), .i_start(start25), .i_c_init(ci25), .i_len(len25),
        .i_abort(1'b0), .i_ready(1'b1), .o_seq(seq25), .o_valid(valid25), .o_last(last25),
        .o_busy(busy25), .o_done(done25)
    );

    gold_seq_gen #(.N_GEN_BIT(1), .NC(NC), .LEN_W(LW)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(start1), .i_c_init(ci1), .i_len(len1),
        .i_abort(1'b0), .i_ready(1'b1), .o_seq(seq1), .o_valid(valid1), .o_last(last1),
        .o_busy(busy1), .o_done(done1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // c(off..off+MAXL-1) computed bit-serially straight from the two recurrences.
    function automatic logic [MAXL-1:0] gold_vec(input logic [30:0] ci, input int off);
        bit x1[NC+MAXL+31];
        bit x2[NC+MAXL+31];
        logic [MAXL-1:0] v;
        for (int i = 0; i < 31; i++) begin
            x1[i] = (i == 0);
            x2[i] = ci[i];
        end
        for (int n = 0; n + 31 < off + MAXL; n++) begin
            x1[n+31] = x1[n+3] ^ x1[n];
            x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
        end
        for (int k = 0; k < MAXL; k++) v[k] = x1[off+k] ^ x2[off+k];
        return v;
    endfunction

    // Behavioural model of the 8-bit instance: request phase, word index, done pulse.
    int              m_state;   // 0 idle, 1 warm-up, 2 streaming
    int              m_warm, m_idx, m_len, hs_cnt;
    logic [MAXL-1:0] m_vec;
    bit              m_done, m_nd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0;
            m_done  = 1'b0;
        end else begin
            m_nd = 1'b0;
            if (valid && ready) hs_cnt++;
            case (m_state)
                0: if (start && len != 0) begin
                    m_vec   = gold_vec(c_init, NC);
                    m_len   = int'(len);
                    m_idx   = 0;
                    m_warm  = NC / NG;
                    m_state = 1;
                end
                1: if (abort) m_state = 0;
                   else begin
                       m_warm--;
                       if (m_warm == 0) m_state = 2;
                   end
                2: if (abort) m_state = 0;
                   else if (ready) begin
                       m_idx += NG;
                       if (m_idx >= m_len) begin
                           m_state = 0;
                           m_nd    = 1'b1;
                       end
                   end
                default: m_state = 0;
            endcase
            m_done = m_nd;
        end
    end

    logic [NG-1:0] e_seq;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("valid", valid, m_state == 2);
            check("busy", busy, m_state != 0);
            check("done", done, m_done);
            if (m_state == 2) begin
                for (int k = 0; k < NG; k++) e_seq[k] = (m_idx + k < m_len) ? m_vec[m_idx+k] : 1'b0;
                check("seq", seq, e_seq);
                check("last", last, (m_len - m_idx) <= NG);
            end
        end
    end

    task automatic issue(input logic [30:0] ci, input logic [LW-1:0] l);
        @(negedge clk);
        start  = 1'b1;
        c_init = ci;
        len    = l;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_idle(input int pct, input int bound, input string nm);
        int cyc = 0;
        while (m_state != 0 && cyc < bound) begin
            @(negedge clk);
            ready = ($urandom_range(0, 99) < pct);
            cyc++;
        end
        check({nm, "_finished"}, m_state == 0, 1'b1);
    endtask

    // 25-bit and 1-bit builds: collect every streamed bit and compare at the end.
    bit q25[$];
    bit q1[$];
    int w25 = 0, w1 = 0, last_at25 = 0, last_at1 = 0;
    bit seen25 = 0, seen1 = 0, extra_done = 0;

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            if (valid25) begin
                for (int k = 0; k < 25; k++) q25.push_back(seq25[k]);
                w25++;
                if (last25) last_at25 = w25;
            end
            if (valid1) begin
                q1.push_back(seq1[0]);
                w1++;
                if (last1) last_at1 = w1;
            end
            if (done25) seen25 = 1'b1;
            if (done1)  seen1  = 1'b1;
        end
    end

    initial begin
        logic [MAXL-1:0] v;
        int nmis, cyc;
        start25 = 1'b0; start1 = 1'b0;
        ci25 = '0; ci1 = '0; len25 = '0; len1 = '0;
        wait (rst_n === 1'b1);
        @(negedge clk);
        start25 = 1'b1; ci25 = 31'($urandom); len25 = 16'd100;
        start1  = 1'b1; ci1  = 31'($urandom); len1  = 16'd40;
        @(negedge clk);
        start25 = 1'b0;
        start1  = 1'b0;
        check("n25_busy", busy25, 1'b1);
        cyc = 0;
        while (!(seen25 && seen1) && cyc < 2500) begin
            @(negedge clk);
            cyc++;
        end
        check("n25_done_seen", seen25, 1'b1);
        check("n1_done_seen", seen1, 1'b1);
        check("n25_words", w25, 4);
        check("n25_last_word", last_at25, 4);
        check("n1_words", w1, 40);
        check("n1_last_word", last_at1, 40);
        v = gold_vec(ci25, NC);
        nmis = 0;
        for (int i = 0; i < 100 && i < q25.size(); i++) if (q25[i] !== v[i]) nmis++;
        check("n25_bit_errors", nmis, 0);
        v = gold_vec(ci1, NC);
        nmis = 0;
        for (int i = 0; i < 40 && i < q1.size(); i++) if (q1[i] !== v[i]) nmis++;
        check("n1_bit_errors", nmis, 0);
        extra_done = 1'b1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before the test sequence ended");
        n_cmp++;
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        logic [MAXL-1:0] pv;
        int lat, cyc;
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; ready = 1'b0;
        c_init = '0; len = '0;

        // Model pins: with no offset, c = x1 ^ x2 over the first 32 positions.
        pv = gold_vec(31'd0, 0);
        check("pin_ci0", pv[31:0], 32'h8000_0001);
        pv = gold_vec(31'd1, 0);
        check("pin_ci1", pv[31:0], 32'h0000_0000);
        pv = gold_vec(31'h0000_000F, 0);
        check("pin_ciF", pv[31:0], 32'h8000_000E);

        #12;
        check("rst_valid", valid, 1'b0);
        check("rst_last", last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_seq", seq, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // c_init = 0, 64 bits, ready held high: 200-cycle warm-up then 8 words.
        hs_cnt = 0;
        ready  = 1'b1;
        issue(31'd0, 16'd64);
        lat = 0;
        while (!valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        check("first_valid_latency", lat, 200);
        wait_idle(100, 50, "len64");
        check("len64_handshakes", hs_cnt, 8);

        hs_cnt = 0;
        issue(31'h1234_5678, 16'd20);
        wait_idle(100, 300, "len20");
        check("len20_handshakes", hs_cnt, 3);

        hs_cnt = 0;
        issue(31'($urandom), 16'd1000);
        wait_idle(50, 3000, "len1000");
        check("len1000_handshakes", hs_cnt, 125);

        // Abort during warm-up, then on the third streamed word.
        ready = 1'b1;
        issue(31'($urandom), 16'd64);
        repeat (49) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_warm_busy", busy, 1'b0);
        hs_cnt = 0;
        issue(31'($urandom), 16'd64);
        cyc = 0;
        while (hs_cnt < 2 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reach_word3", hs_cnt, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_run_busy", busy, 1'b0);
        check("abort_run_done", done, 1'b0);
        hs_cnt = 0;
        issue(31'($urandom), 16'd48);
        wait_idle(70, 600, "after_abort");
        check("after_abort_handshakes", hs_cnt, 6);

        // Zero length is ignored.
        issue(31'($urandom), 16'd0);
        check("len0_busy", busy, 1'b0);

        // A second start while busy is ignored.
        hs_cnt = 0;
        ready  = 1'b1;
        issue(31'($urandom), 16'd40);
        repeat (10) @(negedge clk);
        issue(31'($urandom), 16'd8);
        wait_idle(100, 400, "busy_start");
        check("busy_start_handshakes", hs_cnt, 5);

        // Start presented in the o_done cycle is accepted.
        ready = 1'b1;
        issue(31'($urandom), 16'd16);
        cyc = 0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen_for_restart", done, 1'b1);
        hs_cnt = 0;
        start  = 1'b1;
        c_init = 31'($urandom);
        len    = 16'd24;
        @(negedge clk);
        start = 1'b0;
        check("restart_in_done_busy", busy, 1'b1);
        wait_idle(100, 400, "restart");
        check("restart_handshakes", hs_cnt, 3);

        // Random requests under random backpressure.
        for (int r = 0; r < 6; r++) begin
            int l, pct;
            l   = $urandom_range(1, 200);
            pct = $urandom_range(30, 100);
            hs_cnt = 0;
            issue(31'($urandom), 16'(l));
            wait_idle(pct, 2000, "random_req");
            check("random_handshakes", hs_cnt, (l + NG - 1) / NG);
        end

        cyc = 0;
        while (!extra_done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("extra_builds_finished", extra_done, 1'b1);

        // Asynchronous reset mid-stream.
        ready = 1'b1;
        issue(31'($urandom), 16'd500);
        repeat (230) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", valid, 1'b0);
        check("midrst_last", last, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_seq", seq, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_busy", busy, 1'b0);
        hs_cnt = 0;
        issue(31'($urandom), 16'd33);
        wait_idle(80, 600, "postrst");
        check("postrst_handshakes", hs_cnt, 5);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
